// File: rtl/rng_pkg.sv
// Shared types and widths for the LFSR entropy collector.
// Sample, word and counter sizes used by the collector and its FIFO.
package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COLLECT,
    ST_FAULT
  } state_t;

  localparam int SAMPLE_W         = 16;
  localparam int WORD_W           = 64;
  localparam int SAMPLES_PER_WORD = 4;
  localparam int REP_CNT_W        = 4;
  localparam int PCNT_W           = $clog2(SAMPLES_PER_WORD);
  localparam int PACK_W           = SAMPLE_W * (SAMPLES_PER_WORD - 1);

endpackage

// File: rtl/rng_word_fifo.sv
// Small word FIFO with synchronous flush for packed random words.
// Pointers carry an extra wrap bit so full and empty are unambiguous.
module rng_word_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/rng_collector_64.sv
// Seeds the 16-bit LFSR, health-tests its samples and packs
// four accepted samples per 64-bit word into an output FIFO.
module rng_collector_64
  import rng_pkg::*;
#(
  parameter int REP_LIMIT  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [SAMPLE_W-1:0] seed_i,
  output logic                load_o,
  output logic [SAMPLE_W-1:0] seed_o,
  input  logic [SAMPLE_W-1:0] entropy16_i,
  input  logic                entropy16_valid_i,
  output logic [WORD_W-1:0]   rnd_o,
  output logic                rnd_valid_o,
  input  logic                rnd_ready_i,
  output logic                fault_o,
  output logic                busy_o
);

  state_t                r_state;
  logic                  r_load;
  logic                  r_busy;
  logic                  r_fault;
  logic [SAMPLE_W-1:0]   r_seed;
  logic [PACK_W-1:0]     r_pack;
  logic [PCNT_W-1:0]     r_pcnt;
  logic [REP_CNT_W-1:0]  r_rep;
  logic [SAMPLE_W-1:0]   r_prev;
  logic                  r_have_prev;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_trip;
  logic                  w_push;
  logic                  w_flush;
  logic                  w_last;
  logic [REP_CNT_W-1:0]  w_rep_nxt;
  logic [WORD_W-1:0]     w_word;
  logic [WORD_W-1:0]     w_head;

  // Full is judged on current occupancy; a same-cycle pop frees nothing.
  assign w_accept = (r_state == ST_COLLECT) && entropy16_valid_i &&
                    !w_full && !start_i;

  always_comb begin
    w_rep_nxt = REP_CNT_W'(1);
    if (r_have_prev && (entropy16_i == r_prev))
      w_rep_nxt = r_rep + REP_CNT_W'(1);
  end

  assign w_trip  = w_accept && (w_rep_nxt == REP_CNT_W'(REP_LIMIT));
  assign w_last  = (r_pcnt == PCNT_W'(SAMPLES_PER_WORD - 1));
  assign w_word  = {entropy16_i, r_pack};
  assign w_push  = w_accept && !w_trip && w_last;
  assign w_flush = start_i || w_trip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
      r_seed  <= '0;
    end else if (start_i) begin
      r_state <= ST_LOAD;
      r_load  <= 1'b1;
      r_busy  <= 1'b1;
      r_fault <= 1'b0;
      r_seed  <= seed_i;
    end else begin
      unique case (r_state)
        ST_LOAD: begin
          r_state <= ST_COLLECT;
          r_load  <= 1'b0;
        end
        ST_COLLECT: begin
          if (w_trip) begin
            r_state <= ST_FAULT;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
          end
        end
        ST_IDLE, ST_FAULT: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pack      <= '0;
      r_pcnt      <= '0;
      r_rep       <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
    end else if (w_flush) begin
      r_pack      <= '0;
      r_pcnt      <= '0;
      r_rep       <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
    end else if (w_accept) begin
      r_prev      <= entropy16_i;
      r_have_prev <= 1'b1;
      r_rep       <= w_rep_nxt;
      if (w_last) begin
        r_pcnt <= '0;
      end else begin
        r_pack[r_pcnt*SAMPLE_W +: SAMPLE_W] <= entropy16_i;
        r_pcnt <= r_pcnt + PCNT_W'(1);
      end
    end
  end

  rng_word_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (rnd_valid_o && rnd_ready_i),
    .i_flush (w_flush),
    .i_data  (w_word),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (w_head)
  );

  assign rnd_valid_o = !w_empty;
  assign rnd_o       = w_empty ? '0 : w_head;
  assign load_o      = r_load;
  assign seed_o      = r_seed;
  assign busy_o      = r_busy;
  assign fault_o     = r_fault;

endmodule

// File: tb/tb_rng_collector_64.sv
// Bench for rng_collector_64: LFSR generator, reference model
// with expected-word queue, and a monitor that pops on each transfer.
module tb_rng_collector_64;

  localparam int DEPTH = 2;
  localparam int REP   = 4;
  localparam logic [15:0] POLY = 16'hB400;
  localparam logic [63:0] W_ACE1 = 64'h1C4E_389C_7138_E270;
  localparam logic [63:0] W_1234 = 64'h5B23_B646_048D_091A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] seed_i = '0;
  logic        load_o;
  logic [15:0] seed_o;
  logic [15:0] entropy16_i;
  logic        entropy16_valid_i;
  logic [63:0] rnd_o;
  logic        rnd_valid_o;
  logic        rnd_ready_i = 1'b0;
  logic        fault_o;
  logic        busy_o;

  always #5 clk = ~clk;

  rng_collector_64 #(
    .REP_LIMIT  (REP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start_i),
    .seed_i            (seed_i),
    .load_o            (load_o),
    .seed_o            (seed_o),
    .entropy16_i       (entropy16_i),
    .entropy16_valid_i (entropy16_valid_i),
    .rnd_o             (rnd_o),
    .rnd_valid_o       (rnd_valid_o),
    .rnd_ready_i       (rnd_ready_i),
    .fault_o           (fault_o),
    .busy_o            (busy_o)
  );

  int checks = 0;
  int failures = 0;
  int pops = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Galois LFSR generator: load cycle outputs seed with valid low.
  logic [15:0] g_s = '0;
  logic        g_v = 1'b0;
  logic        g_run = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      g_s <= '0; g_v <= 1'b0; g_run <= 1'b0;
    end else if (load_o) begin
      g_s <= seed_o; g_v <= 1'b0; g_run <= 1'b1;
    end else if (g_run) begin
      g_s <= lfsr(g_s); g_v <= 1'b1;
    end
  end
  assign entropy16_i = g_s;
  assign entropy16_valid_i = g_v;

  // Reference model: 0 idle, 1 load, 2 collect, 3 fault.
  int          m_st = 0;
  int          m_occ = 0;
  int          m_pcnt = 0;
  int          m_rep = 0;
  bit          m_first = 1'b1;
  bit          m_fault = 1'b0;
  bit          m_load = 1'b0;
  bit          m_busy = 1'b0;
  logic [47:0] m_pack = '0;
  logic [15:0] m_prev = '0;
  logic [63:0] exp_q[$];
  int          mo;
  int          mr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_occ <= 0; m_pcnt <= 0; m_rep <= 0; m_first <= 1'b1;
      m_fault <= 1'b0; m_load <= 1'b0; m_busy <= 1'b0;
      m_pack <= '0; m_prev <= '0;
      exp_q.delete();
    end else begin
      mo = m_occ;
      if (mo > 0 && rnd_ready_i) mo--;
      if (start_i) begin
        m_st <= 1; m_load <= 1'b1; m_busy <= 1'b1; m_fault <= 1'b0;
        m_pcnt <= 0; m_rep <= 0; m_first <= 1'b1;
        mo = 0;
        exp_q.delete();
      end else begin
        m_load <= 1'b0;
        if (m_st == 1) begin
          m_st <= 2;
        end else if (m_st == 2 && entropy16_valid_i && m_occ < DEPTH) begin
          mr = (!m_first && entropy16_i == m_prev) ? m_rep + 1 : 1;
          m_rep <= mr; m_prev <= entropy16_i; m_first <= 1'b0;
          if (mr == REP) begin
            m_st <= 3; m_fault <= 1'b1; m_busy <= 1'b0; m_pcnt <= 0;
            mo = 0;
            exp_q.delete();
          end else if (m_pcnt == 3) begin
            exp_q.push_back({entropy16_i, m_pack});
            mo++;
            m_pcnt <= 0;
          end else begin
            m_pack[m_pcnt*16 +: 16] <= entropy16_i;
            m_pcnt <= m_pcnt + 1;
          end
        end
      end
      m_occ <= mo;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", {63'd0, rnd_valid_o}, {63'd0, m_occ != 0});
      chk("fault", {63'd0, fault_o}, {63'd0, m_fault});
      chk("busy", {63'd0, busy_o}, {63'd0, m_busy});
      chk("load", {63'd0, load_o}, {63'd0, m_load});
      if (rnd_valid_o && rnd_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL word_unexpected got=%h exp=none", rnd_o);
        end else begin
          chk("word", rnd_o, exp_q.pop_front());
        end
        pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] seed, input logic [63:0] w0,
                          input bit zero);
    start_i = 1'b1;
    seed_i  = seed;
    tick();
    start_i = 1'b0;
    chk("load_c1", {63'd0, load_o}, 64'd1);
    chk("seed_o", {48'd0, seed_o}, {48'd0, seed});
    chk("valid_c1", {63'd0, rnd_valid_o}, 64'd0);
    for (int c = 2; c <= 7; c++) begin
      tick();
      chk("load_off", {63'd0, load_o}, 64'd0);
      chk("valid_lat", {63'd0, rnd_valid_o}, {63'd0, (c == 7) && !zero});
    end
    if (zero) chk("fault_c7", {63'd0, fault_o}, 64'd1);
    else      chk("word0", rnd_o, w0);
  endtask

  task automatic wait_pops(input int n, input string nm);
    int t;
    int target;
    t = 0;
    target = pops + n;
    while (pops < target && t < 400) begin
      tick();
      t++;
    end
    checks++;
    if (pops < target) begin
      failures++;
      $display("FAIL %s timeout got=%0d exp=%0d", nm, pops, target);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, {63'd0, rnd_valid_o}, 64'd0);
    chk({nm, "_rnd"}, rnd_o, 64'd0);
    chk({nm, "_seed"}, {48'd0, seed_o}, 64'd0);
    chk({nm, "_load"}, {63'd0, load_o}, 64'd0);
    chk({nm, "_busy"}, {63'd0, busy_o}, 64'd0);
    chk({nm, "_fault"}, {63'd0, fault_o}, 64'd0);
  endtask

  logic [63:0] held;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_zero("rst");
    repeat (5) tick();
    chk("idle_load", {63'd0, load_o}, 64'd0);

    rnd_ready_i = 1'b1;
    do_start(16'hACE1, W_ACE1, 1'b0);
    wait_pops(9, "nominal");
    chk("nom_fault", {63'd0, fault_o}, 64'd0);

    do_start(16'h0000, 64'd0, 1'b1);
    repeat (20) tick();
    chk("stuck_fault", {63'd0, fault_o}, 64'd1);
    chk("stuck_valid", {63'd0, rnd_valid_o}, 64'd0);

    rnd_ready_i = 1'b0;
    do_start(16'hACE1, W_ACE1, 1'b0);
    repeat (6) tick();
    held = rnd_o;
    chk("bp_head", held, W_ACE1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bp_stable", rnd_o, held);
      chk("bp_valid", {63'd0, rnd_valid_o}, 64'd1);
    end
    rnd_ready_i = 1'b1;
    wait_pops(6, "drain");

    rnd_ready_i = 1'b0;
    do_start(16'hACE1, W_ACE1, 1'b0);
    tick();
    do_start(16'h1234, W_1234, 1'b0);
    rnd_ready_i = 1'b1;
    wait_pops(3, "restart");

    do_start(16'hACE1, W_ACE1, 1'b0);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 chk_zero("arst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_start(16'hACE1, W_ACE1, 1'b0);
    wait_pops(9, "rerun");
    chk("rerun_fault", {63'd0, fault_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
